// File: rtl/count_arbiter_if.sv
// Requester-side bundle for count_arbiter: two request/target pairs in,
// shared count, direction, busy, grants and done strobes out.
interface count_arbiter_if #(
   parameter int unsigned WIDTH = 3
);
   logic             req_a;
   logic [WIDTH-1:0] tgt_a;
   logic             req_b;
   logic [WIDTH-1:0] tgt_b;
   logic [WIDTH-1:0] q;
   logic             m;
   logic             busy;
   logic             gnt_a;
   logic             gnt_b;
   logic             done_a;
   logic             done_b;

   modport master (
      output req_a, tgt_a, req_b, tgt_b,
      input  q, m, busy, gnt_a, gnt_b, done_a, done_b
   );

   modport slave (
      input  req_a, tgt_a, req_b, tgt_b,
      output q, m, busy, gnt_a, gnt_b, done_a, done_b
   );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin arbiter for two requesters sharing one up/down counter; the
// granted requester's target is latched and the count stepped toward it.
module count_arbiter #(
   parameter int unsigned WIDTH = 3
) (
   input  logic           clk,
   input  logic           clr,
   count_arbiter_if.slave bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             m_q, m_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;
   logic             last_b_q, last_b_d;
   logic             own_req;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         q_q      <= '0;
         tgt_q    <= '0;
         m_q      <= 1'b0;
         gnt_a_q  <= 1'b0;
         gnt_b_q  <= 1'b0;
         last_b_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         tgt_q    <= tgt_d;
         m_q      <= m_d;
         gnt_a_q  <= gnt_a_d;
         gnt_b_q  <= gnt_b_d;
         last_b_q <= last_b_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      tgt_d    = tgt_q;
      m_d      = m_q;
      gnt_a_d  = gnt_a_q;
      gnt_b_d  = gnt_b_q;
      last_b_d = last_b_q;
      own_req  = gnt_a_q ? bus.req_a : bus.req_b;

      case (state_q)
         IDLE: begin
            // On a tie A wins only if B was served (or aborted) last.
            if (bus.req_a && (!bus.req_b || last_b_q)) begin
               tgt_d   = bus.tgt_a;
               m_d     = (q_q > bus.tgt_a);
               gnt_a_d = 1'b1;
               state_d = RUN;
            end else if (bus.req_b) begin
               tgt_d   = bus.tgt_b;
               m_d     = (q_q > bus.tgt_b);
               gnt_b_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!own_req) begin
               last_b_d = gnt_b_q;
               gnt_a_d  = 1'b0;
               gnt_b_d  = 1'b0;
               state_d  = IDLE;
            end else if (q_q == tgt_q) begin
               state_d = DONE;
            end else begin
               q_d = m_q ? (q_q - ONE) : (q_q + ONE);
            end
         end
         DONE: begin
            last_b_d = gnt_b_q;
            gnt_a_d  = 1'b0;
            gnt_b_d  = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.q      = q_q;
   assign bus.m      = m_q;
   assign bus.busy   = (state_q != IDLE);
   assign bus.gnt_a  = gnt_a_q;
   assign bus.gnt_b  = gnt_b_q;
   assign bus.done_a = (state_q == DONE) && gnt_a_q;
   assign bus.done_b = (state_q == DONE) && gnt_b_q;
endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: directed scenarios followed by random traffic,
// every cycle compared with a grant-schedule reference model.
module tb_count_arbiter;
   localparam int unsigned W = 3;

   logic         clk;
   logic         clr;
   logic         ra, rb;
   logic [W-1:0] ta, tb_t;

   int unsigned  n_cmp;
   int unsigned  n_err;

   // Reference model: owner 0=none 1=A 2=B; p = edges since grant.
   int unsigned  mo_owner, mo_p, mo_d, mo_last, mo_start, mo_tgt, mo_q;
   bit           mo_dir;

   count_arbiter_if #(.WIDTH(W)) bus ();

   count_arbiter #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   assign bus.req_a = ra;
   assign bus.tgt_a = ta;
   assign bus.req_b = rb;
   assign bus.tgt_b = tb_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mo_owner = 0;
      mo_p     = 0;
      mo_d     = 0;
      mo_last  = 2;
      mo_start = 0;
      mo_tgt   = 0;
      mo_q     = 0;
      mo_dir   = 1'b0;
   endtask

   task automatic model_edge();
      int unsigned w;
      int unsigned k;
      w = 0;
      if (mo_owner == 0) begin
         if (ra && rb)   w = (mo_last == 1) ? 2 : 1;
         else if (ra)    w = 1;
         else if (rb)    w = 2;
         if (w != 0) begin
            mo_owner = w;
            mo_tgt   = (w == 1) ? int'(ta) : int'(tb_t);
            mo_start = mo_q;
            mo_dir   = (mo_q > mo_tgt);
            mo_d     = mo_dir ? (mo_q - mo_tgt) : (mo_tgt - mo_q);
            mo_p     = 0;
         end
      end else if (mo_p > mo_d) begin
         mo_last  = mo_owner;
         mo_owner = 0;
      end else if (!((mo_owner == 1) ? ra : rb)) begin
         mo_last  = mo_owner;
         mo_owner = 0;
      end else begin
         mo_p++;
         k    = (mo_p < mo_d) ? mo_p : mo_d;
         mo_q = mo_dir ? (mo_start - k) : (mo_start + k);
      end
   endtask

   task automatic compare();
      bit in_done;
      in_done = (mo_owner != 0) && (mo_p == mo_d + 1);
      check("q",      32'(bus.q),      32'(mo_q));
      check("m",      32'(bus.m),      32'(mo_dir));
      check("busy",   32'(bus.busy),   32'(mo_owner != 0));
      check("gnt_a",  32'(bus.gnt_a),  32'(mo_owner == 1));
      check("gnt_b",  32'(bus.gnt_b),  32'(mo_owner == 2));
      check("done_a", 32'(bus.done_a), 32'(in_done && mo_owner == 1));
      check("done_b", 32'(bus.done_b), 32'(in_done && mo_owner == 2));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic steps(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   // Asserted between edges; outputs must clear with no clock edge.
   task automatic async_reset();
      clr = 1'b0;
      #1;
      model_reset();
      compare();
      @(negedge clk);
      clr = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clr   = 1'b0;
      ra    = 1'b0;
      rb    = 1'b0;
      ta    = '0;
      tb_t  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      clr = 1'b1;

      // Single request A to 5: done after edge 7, idle after edge 8.
      ra = 1'b1; ta = W'(5);
      steps(7);
      ra = 1'b0;
      step();

      // Count down from 5 to 2 with B.
      rb = 1'b1; tb_t = W'(2);
      steps(5);
      rb = 1'b0;
      steps(2);

      // Tie with both held: grants alternate A, B, A, B.
      async_reset();
      ra = 1'b1; ta = W'(3);
      rb = 1'b1; tb_t = W'(0);
      steps(26);
      ra = 1'b0; rb = 1'b0;
      steps(6);

      // Zero distance: q=3 and target 3.
      async_reset();
      ra = 1'b1; ta = W'(3);
      steps(5);
      ra = 1'b0;
      steps(2);
      ra = 1'b1;
      steps(2);
      ra = 1'b0;
      steps(2);

      // Abort at q=2 with B pending; B takes the next IDLE edge.
      async_reset();
      ra = 1'b1; ta = W'(7);
      rb = 1'b1; tb_t = W'(5);
      steps(3);
      ra = 1'b0;
      steps(9);
      rb = 1'b0;
      steps(2);

      // Async reset while counting 0 -> 6 at q=4; A then wins a tie.
      async_reset();
      ra = 1'b1; ta = W'(6);
      steps(5);
      async_reset();
      rb = 1'b1; tb_t = W'(1);
      steps(4);
      ra = 1'b0; rb = 1'b0;
      steps(12);

      // Random traffic driven from the model's view of ownership.
      for (int unsigned c = 0; c < 1500; c++) begin
         bit a_done, b_done;
         a_done = (mo_owner == 1) && (mo_p == mo_d + 1);
         b_done = (mo_owner == 2) && (mo_p == mo_d + 1);
         if (!ra) begin
            if ($urandom_range(0, 9) < 4) ra = 1'b1;
         end else if (a_done) begin
            if ($urandom_range(0, 9) < 7) ra = 1'b0;
         end else if (mo_owner == 1) begin
            if ($urandom_range(0, 19) == 0) ra = 1'b0;
         end
         if (!rb) begin
            if ($urandom_range(0, 9) < 4) rb = 1'b1;
         end else if (b_done) begin
            if ($urandom_range(0, 9) < 7) rb = 1'b0;
         end else if (mo_owner == 2) begin
            if ($urandom_range(0, 19) == 0) rb = 1'b0;
         end
         if ($urandom_range(0, 9) < 3) ta   = W'($urandom_range(0, (1 << W) - 1));
         if ($urandom_range(0, 9) < 3) tb_t = W'($urandom_range(0, (1 << W) - 1));
         if ($urandom_range(0, 299) == 0) async_reset();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/count_arbiter.md
# count_arbiter

Two-requester arbiter and sequencer for the team's 3-bit up/down counter datapath. Each requester presents a target count. The block grants the shared counter round-robin, picks the direction (mode bit `m`), and steps the count one per clock until it equals the granted target. It then pulses a done strobe to the granted requester. The counter register sits inside the block as a synchronous up/down register, so the block owns both the sequencing and the count value.

## Interface
- `WIDTH`, default 3: counter and target width in bits.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `clr`  in  1  reset; asynchronous assertion, active-low.
- `req_a`  in  1  requester A wants the counter; hold high until `done_a` or abort.
- `tgt_a`  in  WIDTH  A's target count; sampled only at grant.
- `req_b`  in  1  requester B request, same rules as A.
- `tgt_b`  in  WIDTH  B's target count.
- `q`  out  WIDTH  current count.
- `m`  out  1  direction: 0 = up, 1 = down; valid while `busy`.
- `busy`  out  1  high in RUN and DONE.
- `gnt_a`, `gnt_b`  out  1 each  one-hot grant; high from grant through the DONE cycle.
- `done_a`, `done_b`  out  1 each  single-cycle completion strobe, in DONE only.

## Operation
- Reset (`clr`=0, asynchronous, any state):
  - `q`=0, `m`=0, `busy`=0, all grants and dones 0.
  - State goes to IDLE.
  - Round-robin pointer `last` = B, so A wins the first tie.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If neither request is high, stay in IDLE with `q` held.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not equal to `last`.
  - On the grant edge:
    - latch the granted target into internal `tgt`;
    - set the grant;
    - set `m` = (`q` > `tgt`);
    - state goes to RUN.
- RUN, on each edge, evaluated in priority order:
  1. Granted request low (abort): state to IDLE, grant clears, no done, `q` holds, `last` = aborted requester.
  2. `q` == `tgt`: state to DONE; done strobe of the granted requester asserts.
  3. Otherwise `q` steps by 1: up if `m`=0, down if `m`=1.
- Direction `m` is fixed at grant and recomputed only at the next grant.
- Arithmetic is unsigned and never wraps. The step direction always moves `q` toward `tgt` without passing 0 or 2^WIDTH−1.
- DONE (one cycle):
  - done strobe high and grant still high;
  - next edge: state to IDLE, grant and done clear, `last` = served requester.
- Targets are ignored outside the grant edge; changing `tgt_x` during RUN has no effect.
- A requester may re-assert `req` immediately after done. It waits one IDLE cycle, and if the other requester is pending, the other one wins.
- Both grants are never high together. Done only asserts alongside its own grant.

## Timing
- Edge 1 is the edge at which IDLE samples the request; distance d = |`tgt` − `q`|.
  - Grant and `busy` are visible after edge 1.
  - `q` reaches `tgt` after edge 1+d.
  - Done is visible after edge d+2 and lasts one cycle.
  - IDLE is re-entered after edge d+3.
- d = 0: done visible after edge 2.
- Minimum spacing between back-to-back grants is d+3 cycles. There is no grant in the cycle after DONE; that cycle is IDLE.
- An abort takes effect on the edge that samples `req` low. No further `q` step occurs on that edge.
- `clr` deassertion: the first active edge is the first rising edge after `clr` goes high.

## Test plan
- Reset then single request: `clr` low, then high; `req_a`=1, `tgt_a`=5.
  - `gnt_a` rises after edge 1.
  - `q` goes 1,2,3,4,5 on edges 2–6 with `m`=0.
  - `done_a` is high for exactly the cycle after edge 7.
  - `busy` falls after edge 8.
- Count down: start with `q`=5, `req_b`=1, `tgt_b`=2.
  - `m`=1.
  - `q` goes 4,3,2 on edges 2–4.
  - `done_b` is high after edge 5.
  - `gnt_a` stays 0 throughout.
- Tie and fairness: from reset, `req_a` and `req_b` both held high, targets 3 and 0.
  - Grant order is A, B, A, B.
  - `q` sequence is 0→3, 3→0, repeating.
  - Grants are never both high.
- Zero distance: `q`=3, `req_a` with `tgt_a`=3.
  - Done appears after edge 2.
  - `q` never changes.
- Abort: `req_a`, `tgt_a`=7; drop `req_a` after `q`=2.
  - No `done_a`.
  - `q` holds at 2.
  - A pending `req_b` is granted on the next IDLE edge.
- Async reset mid-RUN: pull `clr` low between edges while `q`=4 is counting to 6.
  - `q`=0, grants 0, `busy` 0 immediately, with no clock edge needed.
  - After release, A wins a tie.
